reg_write_arbiter: RTL

Round-robin write arbiter for a shared `WIDTH`-bit holding register with clear. `NREQ` requesters compete to load the register. The winner's data is captured on the grant edge, and the winner then owns the register for `HOLD` cycles. The block embeds the register itself, so no separate storage instance is needed, and it sits between requesting sequential blocks and any consumer of `q`.

---
 rtl/reg_ctrl_pkg.sv | 24 ++
 rtl/reg_write_arbiter_if.sv | 38 +++
 rtl/reg_write_arbiter_rr_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-control block family.
// Contents:
//   state_e    - two-state arbiter FSM encoding (ST_IDLE=0, ST_BUSY=1)
//   idx_w()    - index width for an N-entry selector ($clog2, at least 1 bit)
//   DEF_*      - default NREQ / WIDTH / HOLD values shared by sibling blocks
package reg_ctrl_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // A one-entry selector still needs a 1-bit index to keep vectors legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_NREQ);

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between the requesters and reg_write_arbiter.
// Signals:
//   req   [NREQ]        per-requester level request
//   wdata [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   gnt   [NREQ]        one-hot registered grant
//   owner [IW]          index of last/current winner
//   q     [WIDTH]       shared register contents
//   busy                grant active
//   upd                 one-cycle pulse after q was loaded
// Modports: master = requester side, slave = arbiter side.
interface reg_write_arbiter_if
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) ();

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         owner;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  upd;

  modport master (
    output req, wdata,
    input  gnt, owner, q, busy, upd
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, q, busy, upd
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Ports:
//   req   [NREQ] in   request vector
//   ptr   [IW]   in   highest-priority index for this search
//   valid        out  at least one request set
//   idx   [IW]   out  first set bit of req at or above ptr, wrapping to 0
module rr_pick
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest hit to ptr is kept last.
  always_comb begin
    int cand_s;
    valid  = 1'b0;
    idx    = {IW{1'b0}};
    cand_s = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = ((int'(ptr) + k) >= NREQ) ? (int'(ptr) + k - NREQ) : (int'(ptr) + k);
      valid  = valid | req[IW'(cand_s)];
      idx    = req[IW'(cand_s)] ? IW'(cand_s) : idx;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter owning a shared WIDTH-bit register.
// The winner's lane is captured into q on the grant edge; the winner then holds
// the grant for HOLD cycles. On the last grant edge a new request is arbitrated
// directly, giving back-to-back grants without an idle cycle.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   bus (slave)  req/wdata in; gnt/owner/q/busy/upd out (all registered)
module reg_write_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  reg_write_arbiter_if.slave bus
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(HOLD);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    ptr_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  gnt_nxt_s;
  logic [IW-1:0]    owner_r;
  logic [IW-1:0]    owner_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             upd_r;
  logic             upd_nxt_s;

  logic             pick_valid_s;
  logic [IW-1:0]    pick_idx_s;
  logic [WIDTH-1:0] lane_s [NREQ];
  logic             hold_active_s;
  logic             load_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Split the flat data bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lane_s[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  // Arbitration is open in IDLE and on the last cycle of a grant only.
  always_comb begin
    hold_active_s = (state_r == ST_BUSY) && (cnt_r != {CW{1'b0}});
    load_s        = (!hold_active_s) && pick_valid_s;
  end

  // State register plus all output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= {IW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      owner_r <= {IW{1'b0}};
      busy_r  <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      q_r     <= q_nxt_s;
      gnt_r   <= gnt_nxt_s;
      owner_r <= owner_nxt_s;
      busy_r  <= busy_nxt_s;
      upd_r   <= upd_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (hold_active_s || load_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    q_nxt_s     = q_r;
    gnt_nxt_s   = gnt_r;
    owner_nxt_s = owner_r;
    busy_nxt_s  = busy_r;
    upd_nxt_s   = 1'b0;
    if (load_s) begin
      q_nxt_s     = lane_s[pick_idx_s];
      gnt_nxt_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
      owner_nxt_s = pick_idx_s;
      upd_nxt_s   = 1'b1;
      busy_nxt_s  = 1'b1;
      cnt_nxt_s   = CW'(HOLD - 1);
      ptr_nxt_s   = (pick_idx_s == IW'(NREQ - 1)) ? {IW{1'b0}} : (pick_idx_s + IW'(1));
    end else if (hold_active_s) begin
      cnt_nxt_s = cnt_r - CW'(1);
    end else begin
      gnt_nxt_s  = {NREQ{1'b0}};
      busy_nxt_s = 1'b0;
      cnt_nxt_s  = {CW{1'b0}};
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.owner = owner_r;
  assign bus.q     = q_r;
  assign bus.busy  = busy_r;
  assign bus.upd   = upd_r;

endmodule
